// File: rtl/lms_adapt_ctrl.sv
// LMS adaptation controller: mu gear-shift, decimated update enable, lock monitor, debug-load arbitration.
// All outputs registered: a decision taken in cycle n is visible in cycle n+1; debug loads are held off by ack, no backpressure otherwise.
module lms_adapt_ctrl #(
  parameter int              NBe      = 9,
  parameter int              NBmu     = 8,
  parameter logic [NBmu-1:0] MU_ACQ   = 8'h10,
  parameter logic [NBmu-1:0] MU_TRK   = 8'h04,
  parameter int              ACQ_LEN  = 600,
  parameter int              DECIM    = 2,
  parameter int              WIN_LOG2 = 6,
  parameter int              TH_LOCK  = 512,
  parameter int              TH_LOSS  = 2048,
  parameter int              LOSS_CNT = 3
) (
  input  logic                      clkA,
  input  logic                      reset,
  input  logic                      i_start,
  input  logic                      i_freeze,
  input  logic [NBe-1:0]            i_e,
  input  logic                      i_load_req,
  output logic                      o_load_ack,
  output logic                      o_coeff_load,
  output logic [NBmu-1:0]           o_mu,
  output logic                      o_adapt_en,
  output logic [2:0]                o_state,
  output logic                      o_locked,
  output logic [NBe-2+WIN_LOG2:0]   o_err_mag
);

  localparam int MW = NBe - 1 + WIN_LOG2;
  localparam int AW = $clog2(ACQ_LEN + 1);
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int LW = $clog2(LOSS_CNT + 1);

  localparam logic [MW-1:0] TH_LOCK_V = MW'(TH_LOCK);
  localparam logic [MW-1:0] TH_LOSS_V = MW'(TH_LOSS);
  localparam logic [AW-1:0] ACQ_LAST  = AW'(ACQ_LEN - 1);
  localparam logic [AW-1:0] ACQ_MAX   = AW'(ACQ_LEN);
  localparam logic [DW-1:0] DEC_LAST  = DW'(DECIM - 1);
  localparam logic [LW-1:0] LOSS_MAX  = LW'(LOSS_CNT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACQ   = 3'd1,
    S_TRACK = 3'd2,
    S_HOLD  = 3'd3,
    S_LOAD  = 3'd4
  } state_t;

  state_t                state_q, state_d, saved_q, saved_d;
  logic [AW-1:0]         acq_cnt_q, acq_cnt_d;
  logic [DW-1:0]         dec_cnt_q, dec_cnt_d;
  logic [LW-1:0]         loss_q, loss_d;
  logic [WIN_LOG2-1:0]   win_cnt_q, win_cnt_d;
  logic [MW-1:0]         acc_q, acc_d, mag_q, mag_d;
  logic                  locked_q, locked_d;
  logic                  ack_q, ack_d, cload_q, cload_d, aen_q, aen_d;
  logic [NBmu-1:0]       mu_q, mu_d;

  logic [NBe-1:0]        neg_e;
  logic [NBe-2:0]        abs_e;
  logic [MW-1:0]         win_sum;
  logic                  running, mon_active, win_end, bad_win, loss_trip, fresh_acq;

  // The most negative sample has no positive twin and saturates to all-ones.
  assign neg_e = ~i_e + NBe'(1);
  always_comb begin
    if (!i_e[NBe-1])              abs_e = i_e[NBe-2:0];
    else if (i_e[NBe-2:0] == '0)  abs_e = '1;
    else                          abs_e = neg_e[NBe-2:0];
  end

  assign running    = (state_q == S_ACQ) || (state_q == S_TRACK);
  assign mon_active = running || (state_q == S_HOLD);
  assign win_sum    = acc_q + MW'(abs_e);
  assign win_end    = mon_active && (win_cnt_q == '1);
  assign bad_win    = win_end && (win_sum > TH_LOSS_V);
  assign loss_trip  = (state_q == S_TRACK) && bad_win && (loss_q >= LOSS_MAX - LW'(1));

  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    acq_cnt_d = acq_cnt_q;
    dec_cnt_d = dec_cnt_q;
    loss_d    = loss_q;
    win_cnt_d = win_cnt_q;
    acc_d     = acc_q;
    mag_d     = mag_q;
    locked_d  = locked_q;
    fresh_acq = 1'b0;

    if (mon_active) begin
      win_cnt_d = win_cnt_q + WIN_LOG2'(1);
      if (win_end) begin
        acc_d = '0;
        mag_d = win_sum;
        if (win_sum < TH_LOCK_V)      locked_d = 1'b1;
        else if (win_sum > TH_LOSS_V) locked_d = 1'b0;
      end else begin
        acc_d = win_sum;
      end
    end else begin
      win_cnt_d = '0;
      acc_d     = '0;
    end

    if (state_q != S_TRACK) loss_d = '0;
    else if (win_end)       loss_d = bad_win ? ((loss_q == LOSS_MAX) ? loss_q : loss_q + LW'(1)) : '0;

    // A load in progress only ends when the request drops; stop/freeze are applied at exit.
    if (state_q == S_LOAD) begin
      if (!i_load_req) begin
        if (!i_start)      state_d = S_IDLE;
        else if (i_freeze) begin
          state_d = S_HOLD;
          saved_d = S_TRACK;
        end else           state_d = S_TRACK;
      end
    end else if (i_load_req && !ack_q) begin
      state_d = S_LOAD;
    end else if (!i_start) begin
      state_d = S_IDLE;
    end else if (i_freeze && running) begin
      state_d = S_HOLD;
      saved_d = state_q;
    end else begin
      case (state_q)
        S_IDLE:  begin
          state_d   = S_ACQ;
          fresh_acq = 1'b1;
        end
        S_ACQ:   if (acq_cnt_q >= ACQ_LAST) state_d = S_TRACK;
        S_TRACK: if (loss_trip) begin
          state_d   = S_ACQ;
          fresh_acq = 1'b1;
        end
        S_HOLD:  if (!i_freeze) state_d = saved_q;
        default: state_d = state_q;
      endcase
    end

    if ((state_q == S_ACQ) && (acq_cnt_q < ACQ_MAX)) acq_cnt_d = acq_cnt_q + AW'(1);
    if (running) dec_cnt_d = (dec_cnt_q == DEC_LAST) ? '0 : dec_cnt_q + DW'(1);
    if (fresh_acq || (state_d == S_LOAD)) dec_cnt_d = '0;
    if (fresh_acq) begin
      acq_cnt_d = '0;
      loss_d    = '0;
    end
    if (state_d == S_IDLE) begin
      locked_d = 1'b0;
      mag_d    = '0;
    end
  end

  always_comb begin
    ack_d   = (state_d == S_LOAD);
    cload_d = (state_d == S_LOAD) && (state_q != S_LOAD);
    aen_d   = ((state_d == S_ACQ) || (state_d == S_TRACK)) && (dec_cnt_d == DEC_LAST);
    case (state_d)
      S_ACQ:   mu_d = MU_ACQ;
      S_TRACK: mu_d = MU_TRK;
      default: mu_d = '0;
    endcase
  end

  always_ff @(posedge clkA or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      saved_q   <= S_ACQ;
      acq_cnt_q <= '0;
      dec_cnt_q <= '0;
      loss_q    <= '0;
      win_cnt_q <= '0;
      acc_q     <= '0;
      mag_q     <= '0;
      locked_q  <= 1'b0;
      ack_q     <= 1'b0;
      cload_q   <= 1'b0;
      aen_q     <= 1'b0;
      mu_q      <= '0;
    end else begin
      state_q   <= state_d;
      saved_q   <= saved_d;
      acq_cnt_q <= acq_cnt_d;
      dec_cnt_q <= dec_cnt_d;
      loss_q    <= loss_d;
      win_cnt_q <= win_cnt_d;
      acc_q     <= acc_d;
      mag_q     <= mag_d;
      locked_q  <= locked_d;
      ack_q     <= ack_d;
      cload_q   <= cload_d;
      aen_q     <= aen_d;
      mu_q      <= mu_d;
    end
  end

  assign o_state      = state_q;
  assign o_mu         = mu_q;
  assign o_adapt_en   = aen_q;
  assign o_load_ack   = ack_q;
  assign o_coeff_load = cload_q;
  assign o_locked     = locked_q;
  assign o_err_mag    = mag_q;

endmodule

// File: tb/tb_lms_adapt_ctrl.sv
// Directed + randomized bench for lms_adapt_ctrl against a cycle-level reference model.
module tb_lms_adapt_ctrl;
  localparam int DECIM = 2;

  logic        clkA;
  logic        reset;
  logic        i_start, i_freeze, i_load_req;
  logic [8:0]  i_e;
  logic        o_load_ack, o_coeff_load, o_adapt_en, o_locked;
  logic [7:0]  o_mu;
  logic [2:0]  o_state;
  logic [13:0] o_err_mag;

  int errors = 0;
  int checks = 0;

  lms_adapt_ctrl dut (
    .clkA(clkA), .reset(reset), .i_start(i_start), .i_freeze(i_freeze), .i_e(i_e),
    .i_load_req(i_load_req), .o_load_ack(o_load_ack), .o_coeff_load(o_coeff_load),
    .o_mu(o_mu), .o_adapt_en(o_adapt_en), .o_state(o_state), .o_locked(o_locked),
    .o_err_mag(o_err_mag)
  );

  initial begin
    clkA = 1'b0;
    forever #5 clkA = ~clkA;
  end

  // Reference model: states 0..4 as in the port description, ACQ time as elapsed cycles,
  // windows as a list of |e| samples summed when 64 have been collected.
  int m_st, m_saved, m_acq, m_ph, m_bad, m_mag, m_lock, m_ack, m_cload;
  int m_win[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int abs_e(input logic [8:0] e);
    int v;
    v = $signed(e);
    if (v < 0) v = (v == -256) ? 255 : -v;
    return v;
  endfunction

  task automatic model_reset();
    m_st = 0; m_saved = 1; m_acq = 0; m_ph = 0; m_bad = 0;
    m_mag = 0; m_lock = 0; m_ack = 0; m_cload = 0;
    m_win.delete();
  endtask

  task automatic model_step();
    int a, sum, ns, nbad, nlock, nmag;
    bit wend, fresh, run, act;
    a = abs_e(i_e);
    run = (m_st == 1) || (m_st == 2);
    act = run || (m_st == 3);
    wend = 0; sum = 0;
    if (act) begin
      m_win.push_back(a);
      if (m_win.size() == 64) begin
        foreach (m_win[k]) sum += m_win[k];
        wend = 1;
        m_win.delete();
      end
    end else m_win.delete();
    nlock = m_lock; nmag = m_mag;
    if (wend) begin
      nmag = sum;
      if (sum < 512) nlock = 1;
      else if (sum > 2048) nlock = 0;
    end
    nbad = m_bad;
    if (m_st != 2) nbad = 0;
    else if (wend) nbad = (sum > 2048) ? ((m_bad < 3) ? m_bad + 1 : 3) : 0;
    ns = m_st; fresh = 0;
    if (m_st == 1) m_acq++;
    if (m_st == 4) begin
      if (!i_load_req) begin
        if (!i_start) ns = 0;
        else if (i_freeze) begin ns = 3; m_saved = 2; end
        else ns = 2;
      end
    end else if (i_load_req && m_ack == 0) ns = 4;
    else if (!i_start) ns = 0;
    else if (i_freeze && run) begin ns = 3; m_saved = m_st; end
    else if (m_st == 0) begin ns = 1; fresh = 1; end
    else if (m_st == 1 && m_acq >= 600) ns = 2;
    else if (m_st == 2 && wend && sum > 2048 && nbad == 3) begin ns = 1; fresh = 1; end
    else if (m_st == 3 && !i_freeze) ns = m_saved;
    if (run) m_ph = (m_ph + 1) % DECIM;
    if (fresh) begin m_acq = 0; m_ph = 0; nbad = 0; end
    if (ns == 4) m_ph = 0;
    if (ns == 0) begin nlock = 0; nmag = 0; end
    m_ack = (ns == 4) ? 1 : 0;
    m_cload = (ns == 4 && m_st != 4) ? 1 : 0;
    m_st = ns; m_bad = nbad; m_lock = nlock; m_mag = nmag;
  endtask

  task automatic check_all();
    int mu, aen;
    mu  = (m_st == 1) ? 8'h10 : (m_st == 2) ? 8'h04 : 0;
    aen = ((m_st == 1 || m_st == 2) && m_ph == DECIM - 1) ? 1 : 0;
    chk("state", 32'(o_state), m_st);
    chk("mu", 32'(o_mu), mu);
    chk("adapt_en", 32'(o_adapt_en), aen);
    chk("locked", 32'(o_locked), m_lock);
    chk("err_mag", 32'(o_err_mag), m_mag);
    chk("load_ack", 32'(o_load_ack), m_ack);
    chk("coeff_load", 32'(o_coeff_load), m_cload);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clkA);
    @(negedge clkA);
    check_all();
  endtask

  initial begin
    int n, n_aen, n_hold, hold_bad, n_cl, n_ack, amp, v, frz_left, ld_left;
    reset = 1'b0; i_start = 0; i_freeze = 0; i_load_req = 0; i_e = '0;
    model_reset();
    @(negedge clkA); @(negedge clkA);
    check_all();
    reset = 1'b1;
    cycle(); cycle();

    // Plain acquisition from IDLE with zero error
    i_start = 1;
    cycle();
    chk("acq_mu", 32'(o_mu), 32'h10);
    n = 0; n_aen = 0;
    for (int k = 0; k < 800 && o_state == 3'd1; k++) begin
      n++; n_aen += int'(o_adapt_en);
      cycle();
    end
    chk("acq_len", n, 600);
    chk("acq_aen_pulses", n_aen, 300);
    chk("track_state", 32'(o_state), 2);
    chk("track_mu", 32'(o_mu), 32'h04);
    chk("acq_locked", 32'(o_locked), 1);
    chk("acq_err_mag", 32'(o_err_mag), 0);

    // Stop, restart, freeze after 200 ACQ cycles
    i_start = 0;
    cycle();
    chk("stop_idle", 32'(o_state), 0);
    chk("stop_unlock", 32'(o_locked), 0);
    i_start = 1;
    cycle();
    for (int k = 1; k < 200; k++) cycle();
    chk("pre_freeze_acq", 32'(o_state), 1);
    i_freeze = 1; n_hold = 0; hold_bad = 0;
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (o_state == 3'd3) n_hold++;
      if (o_mu != 0 || o_adapt_en) hold_bad++;
    end
    chk("hold_len", n_hold, 50);
    chk("hold_quiet", hold_bad, 0);
    i_freeze = 0;
    cycle();
    n = 0;
    for (int k = 0; k < 600 && o_state == 3'd1; k++) begin n++; cycle(); end
    chk("acq_resume_len", n, 400);
    chk("resume_track", 32'(o_state), 2);

    // Loss of lock: window-aligned -256 drive
    for (int k = 0; k < 64 && m_win.size() != 0; k++) cycle();
    i_e = 9'h100;
    for (int k = 0; k < 64; k++) cycle();
    chk("bad_err_mag", 32'(o_err_mag), 16320);
    chk("bad_unlock", 32'(o_locked), 0);
    for (int k = 0; k < 64; k++) cycle();
    chk("bad2_track", 32'(o_state), 2);
    n = 128;
    for (int k = 0; k < 130 && o_state == 3'd2; k++) begin cycle(); n++; end
    chk("reacq_cycles", n, 192);
    chk("reacq_mu", 32'(o_mu), 32'h10);
    i_e = '0;
    for (int k = 0; k < 700 && o_state != 3'd2; k++) cycle();
    chk("reacq_track", 32'(o_state), 2);

    // Debug load in TRACK
    i_load_req = 1; n_cl = 0; n_ack = 0; n_aen = 0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_cl += int'(o_coeff_load); n_ack += int'(o_load_ack); n_aen += int'(o_adapt_en);
    end
    i_load_req = 0;
    cycle();
    chk("load_pulses", n_cl, 1);
    chk("load_ack_cycles", n_ack, 5);
    chk("load_aen", n_aen, 0);
    chk("load_back_track", 32'(o_state), 2);
    chk("load_ack_clr", 32'(o_load_ack), 0);

    // Load with stop during it ends in IDLE
    i_load_req = 1;
    cycle(); cycle();
    i_start = 0;
    cycle(); cycle();
    chk("load_hold_stop", 32'(o_state), 4);
    i_load_req = 0;
    cycle();
    chk("load_stop_idle", 32'(o_state), 0);

    // Load from IDLE with freeze: HOLD then straight to TRACK
    i_start = 1; i_freeze = 1; i_load_req = 1;
    cycle(); cycle(); cycle();
    i_load_req = 0;
    cycle();
    chk("load_freeze_hold", 32'(o_state), 3);
    i_freeze = 0;
    cycle();
    chk("load_skip_acq", 32'(o_state), 2);

    // Stop beats freeze
    i_start = 0; i_freeze = 1;
    cycle();
    chk("stop_frz_state", 32'(o_state), 0);
    chk("stop_frz_mu", 32'(o_mu), 0);
    chk("stop_frz_aen", 32'(o_adapt_en), 0);
    chk("stop_frz_mag", 32'(o_err_mag), 0);
    i_freeze = 0;

    // Randomized run against the model
    amp = 8; frz_left = 0; ld_left = 0;
    for (int it = 0; it < 2500; it++) begin
      if (it % 64 == 0) begin
        case ($urandom_range(0, 3))
          0: amp = 8;
          1: amp = 40;
          2: amp = 300;
          default: amp = 512;
        endcase
      end
      if (amp == 512) v = int'($urandom_range(0, 511)) - 256;
      else begin
        v = int'($urandom_range(0, 2 * amp)) - amp;
        if (v < -256) v = -256;
        if (v > 255) v = 255;
      end
      i_e = 9'(v);
      i_start = ($urandom_range(0, 2999) != 0);
      if (frz_left > 0) begin frz_left--; i_freeze = 1; end
      else begin
        i_freeze = 0;
        if ($urandom_range(0, 299) == 0) frz_left = int'($urandom_range(1, 40));
      end
      if (ld_left > 0) begin ld_left--; i_load_req = 1; end
      else begin
        i_load_req = 0;
        if ($urandom_range(0, 399) == 0) ld_left = int'($urandom_range(1, 6));
      end
      cycle();
    end

    // Asynchronous reset in the middle of a load
    i_start = 1; i_freeze = 0; i_load_req = 0; i_e = '0;
    cycle();
    i_load_req = 1;
    cycle(); cycle();
    chk("pre_rst_load", 32'(o_state), 4);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_ack", 32'(o_load_ack), 0);
    i_load_req = 0; i_start = 0;
    @(negedge clkA);
    reset = 1'b1;
    cycle(); cycle();
    chk("post_rst_idle", 32'(o_state), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
